ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared open-drain ps2_clk/ps2_dat lines. It runs the full request-to-send, bit-shift and acknowledge sequence. It sits beside the keyboard receiver on the same PS/2 pins and is clocked from the 50 MHz board clock.

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
// The client drives the byte and its valid; the transmitter reports readiness and the outcome.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-clock shift, ACK check, bus-idle wait.
// Optional macro PS2_TX_RESEND_EN adds one automatic resend after a NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic         iCLK_50,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  inout  wire          ps2_clk,
  inout  wire          ps2_dat
);
  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE,
    DONE,
    ERR
`ifdef PS2_TX_RESEND_EN
    , RETRY
`endif
  } state_t;

  state_t           state_reg;
  logic             clk_s1_reg, clk_s2_reg, clk_prev_reg;
  logic             dat_s1_reg, dat_s2_reg;
  logic [7:0]       shift_reg;
  logic             parity_reg;
  logic [3:0]       bit_cnt_reg;
  logic [INH_W-1:0] inh_cnt_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             clk_oe_reg, dat_oe_reg;
  logic             ready_reg, busy_reg, done_reg, err_reg;
`ifdef PS2_TX_RESEND_EN
  logic             retry_reg;
`endif

  logic fe;
  logic timing_out;
  logic nack;
  logic fail;

  always_comb begin
    fe         = clk_prev_reg & ~clk_s2_reg;
    timing_out = ((state_reg == REQ) || (state_reg == SHIFT) || (state_reg == WAIT_IDLE)) &&
                 (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
    // The 11th falling edge carries the device's acknowledge on the data line.
    nack       = (state_reg == SHIFT) && fe && (bit_cnt_reg == 4'd10) && dat_s2_reg;
    fail       = timing_out | nack;
  end

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      clk_s1_reg   <= 1'b1;
      clk_s2_reg   <= 1'b1;
      clk_prev_reg <= 1'b1;
      dat_s1_reg   <= 1'b1;
      dat_s2_reg   <= 1'b1;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      bit_cnt_reg  <= '0;
      inh_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      clk_oe_reg   <= 1'b0;
      dat_oe_reg   <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_reg    <= 1'b0;
`endif
    end else begin
      clk_s1_reg   <= ps2_clk;
      clk_s2_reg   <= clk_s1_reg;
      clk_prev_reg <= clk_s2_reg;
      dat_s1_reg   <= ps2_dat;
      dat_s2_reg   <= dat_s1_reg;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;

      if (fail) begin
        // Timeout takes precedence over any edge arriving in the same cycle.
        clk_oe_reg <= 1'b0;
        dat_oe_reg <= 1'b0;
`ifdef PS2_TX_RESEND_EN
        if (!retry_reg) begin
          retry_reg <= 1'b1;
          state_reg <= RETRY;
        end else begin
          retry_reg <= 1'b0;
          err_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ERR;
        end
`else
        err_reg   <= 1'b1;
        busy_reg  <= 1'b0;
        state_reg <= ERR;
`endif
      end else begin
        case (state_reg)
          IDLE: begin
            if (tx.tx_valid && ready_reg) begin
              shift_reg   <= tx.tx_data;
              parity_reg  <= ~^tx.tx_data;
              ready_reg   <= 1'b0;
              busy_reg    <= 1'b1;
              clk_oe_reg  <= 1'b1;
              inh_cnt_reg <= '0;
              state_reg   <= INHIBIT;
            end
          end
          INHIBIT: begin
            inh_cnt_reg <= inh_cnt_reg + 1'b1;
            // Start bit goes low one cycle before the clock is released.
            if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 2)) begin
              dat_oe_reg <= 1'b1;
            end
            if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 1)) begin
              clk_oe_reg  <= 1'b0;
              to_cnt_reg  <= '0;
              bit_cnt_reg <= '0;
              state_reg   <= REQ;
            end
          end
          REQ: begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            state_reg  <= SHIFT;
          end
          SHIFT: begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (fe) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg < 4'd8) begin
                dat_oe_reg <= ~shift_reg[bit_cnt_reg[2:0]];
              end else if (bit_cnt_reg == 4'd8) begin
                dat_oe_reg <= ~parity_reg;
              end else if (bit_cnt_reg == 4'd9) begin
                dat_oe_reg <= 1'b0;
              end else begin
                state_reg <= WAIT_IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (clk_s2_reg && dat_s2_reg) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= DONE;
`ifdef PS2_TX_RESEND_EN
              retry_reg <= 1'b0;
`endif
            end
          end
          DONE, ERR: begin
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
`ifdef PS2_TX_RESEND_EN
          RETRY: begin
            clk_oe_reg  <= 1'b1;
            inh_cnt_reg <= '0;
            state_reg   <= INHIBIT;
          end
`endif
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign ps2_clk     = clk_oe_reg ? 1'b0 : 1'bz;
  assign ps2_dat     = dat_oe_reg ? 1'b0 : 1'bz;
  assign tx.tx_ready = ready_reg;
  assign tx.busy     = busy_reg;
  assign tx.tx_done  = done_reg;
  assign tx.tx_err   = err_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on pulled-up lines, a frame table,
// random bytes checked against an arithmetic frame model, and reset/timeout/held-valid sequences.
module tb_ps2_host_tx;
  localparam int INH  = 5000;
  localparam int TO   = 2000;
  localparam int HALF = 20;
`ifdef PS2_TX_RESEND_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk_50 = 1'b0;
  logic reset  = 1'b0;
  always #10 clk_50 = ~clk_50;

  wire ps2_clk_w;
  wire ps2_dat_w;
  pullup (ps2_clk_w);
  pullup (ps2_dat_w);

  ps2_host_tx_if ifc ();

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .iCLK_50 (clk_50),
    .reset   (reset),
    .tx      (ifc),
    .ps2_clk (ps2_clk_w),
    .ps2_dat (ps2_dat_w)
  );

  // Device side of the bus
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  bit         dev_en      = 1'b1;
  bit         dev_ack     = 1'b1;
  bit         dev_busy    = 1'b0;
  int         dev_k       = 0;
  int         frames      = 0;
  logic [9:0] last_bits   = '0;
  logic       last_start  = 1'b1;

  assign ps2_clk_w = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat_w = dev_dat_low ? 1'b0 : 1'bz;

  initial begin : device
    logic [9:0] bits;
    logic       start;
    bits  = '0;
    start = 1'b1;
    forever begin
      @(posedge clk_50); #2;
      if (dev_en && ps2_clk_w === 1'b0 && ps2_dat_w === 1'b0) begin
        for (int w = 0; w < INH + 10 && ps2_clk_w !== 1'b1; w++) begin
          @(posedge clk_50); #2;
        end
        start    = ps2_dat_w;
        dev_busy = 1'b1;
        for (int k = 1; k <= 11; k++) begin
          dev_k = k;
          repeat (HALF) @(posedge clk_50);
          #2;
          if (k == 11 && dev_ack) begin
            dev_dat_low = 1'b1;
            repeat (2) @(posedge clk_50);
            #2;
          end
          dev_clk_low = 1'b1;
          repeat (HALF) @(posedge clk_50);
          #2;
          if (k <= 10) bits[k-1] = ps2_dat_w;
          dev_clk_low = 1'b0;
          dev_dat_low = 1'b0;
        end
        last_bits  = bits;
        last_start = start;
        frames++;
        dev_k    = 0;
        dev_busy = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  // Frame as the device should see it: data LSB first, odd parity, stop bit.
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic accept(input logic [7:0] d, output bit ok);
    ifc.tx_data  = d;
    ifc.tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = ifc.tx_ready;
      step();
    end
  endtask

  task automatic wait_device_idle();
    for (int i = 0; i < 2000 && dev_busy; i++) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit ack, input bit exp_done,
                            input logic [9:0] exp_bits, input int exp_frames);
    int  f0, n, cyc;
    bit  ok, got_done, got_err;
    logic busy_at;
    dev_ack = ack;
    f0 = frames;
    accept(d, ok);
    ifc.tx_valid = 1'b0;
    check("accept_seen", ok, 1);
    check("busy_ready_after_accept", {ifc.busy, ifc.tx_ready}, 2'b10);
    n = 0;
    while (ps2_clk_w == 1'b0 && n < INH + 50) begin n++; step(); end
    check("inhibit_len", n, INH);
    cyc = 0;
    while (!ifc.tx_done && !ifc.tx_err && cyc < 2 * (INH + TO) + 500) begin cyc++; step(); end
    got_done = ifc.tx_done;
    got_err  = ifc.tx_err;
    busy_at  = ifc.busy;
    check("outcome_done_err", {got_done, got_err}, exp_done ? 2'b10 : 2'b01);
    check("busy_at_pulse", busy_at, 0);
    step();
    check("pulse_width", {ifc.tx_done, ifc.tx_err}, 0);
    check("ready_after_pulse", ifc.tx_ready, 1);
    wait_device_idle();
    check("frame_count", frames - f0, exp_frames);
    check("frame_bits", last_bits, exp_bits);
    check("start_bit", last_start, 0);
    check("lines_released", {ps2_clk_w, ps2_dat_w}, 2'b11);
    $display("tx %02h ack=%0d done=%0d err=%0d frames=%0d bits=%03h", d, ack, got_done, got_err,
             frames - f0, last_bits);
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       parity;
    logic       done;
  } vec_t;

  initial begin : main
    vec_t       vecs [4];
    logic [7:0] d;
    bit         ack, ok, early_ready;
    int         f0, n, cyc, exp_lat;

    vecs[0] = '{data: 8'hED, ack: 1'b1, parity: 1'b1, done: 1'b1};
    vecs[1] = '{data: 8'h01, ack: 1'b1, parity: 1'b0, done: 1'b1};
    vecs[2] = '{data: 8'h00, ack: 1'b1, parity: 1'b1, done: 1'b1};
    vecs[3] = '{data: 8'hFF, ack: 1'b0, parity: 1'b1, done: 1'b0};

    ifc.tx_data  = 8'h00;
    ifc.tx_valid = 1'b0;
    reset        = 1'b0;
    repeat (3) step();
    check("reset_outputs", {ifc.busy, ifc.tx_done, ifc.tx_err}, 0);
    check("reset_lines", {ps2_clk_w, ps2_dat_w}, 2'b11);
    reset = 1'b1;
    step();
    check("ready_after_reset", ifc.tx_ready, 1);
    $display("reset released ready=%0d busy=%0d", ifc.tx_ready, ifc.busy);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].ack, vecs[i].done,
                 {1'b1, vecs[i].parity, vecs[i].data}, vecs[i].ack ? 1 : ATTEMPTS);
    end

    for (int i = 0; i < 2; i++) begin
      d   = 8'($urandom_range(255, 0));
      ack = ($urandom_range(3, 0) != 0);
      send_frame(d, ack, ack, frame_model(d), ack ? 1 : ATTEMPTS);
    end

    // tx_valid held high: one frame, then a second accept only after tx_done
    dev_ack = 1'b1;
    f0 = frames;
    accept(8'h2C, ok);
    check("held_accept", ok, 1);
    early_ready = 1'b0;
    cyc = 0;
    while (!ifc.tx_done && cyc < 2 * (INH + TO) + 500) begin
      if (ifc.tx_ready) early_ready = 1'b1;
      cyc++;
      step();
    end
    check("held_done", ifc.tx_done, 1);
    check("held_no_ready_while_busy", early_ready, 0);
    check("held_one_frame", frames - f0, 1);
    check("held_frame_bits", last_bits, frame_model(8'h2C));
    step();
    check("held_ready_after_done", ifc.tx_ready, 1);
    step();
    check("held_reaccept", {ifc.busy, ifc.tx_ready}, 2'b10);
    $display("held valid: frames=%0d reaccepted busy=%0d", frames - f0, ifc.busy);

    // Reset while the second frame is mid-shift (host driving bit 4 of 0x2C low)
    n = 0;
    while (!(dev_k == 6 && !dev_clk_low) && n < INH + 2000) begin n++; step(); end
    repeat (3) step();
    check("pre_reset_dat_low", ps2_dat_w, 0);
    reset = 1'b0;
    #1;
    check("reset_mid_lines_released", {ps2_clk_w, ps2_dat_w}, 2'b11);
    check("reset_mid_outputs", {ifc.busy, ifc.tx_done, ifc.tx_err}, 0);
    ifc.tx_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("ready_after_mid_reset", ifc.tx_ready, 1);
    $display("reset at bit 5: lines=%0b%0b ready=%0d", ps2_clk_w, ps2_dat_w, ifc.tx_ready);
    wait_device_idle();
    send_frame(8'hF4, 1'b1, 1'b1, {1'b1, 1'b0, 8'hF4}, 1);

    // Silent device: the timeout must fire
    dev_en = 1'b0;
    accept(8'h55, ok);
    ifc.tx_valid = 1'b0;
    check("timeout_accept", ok, 1);
    exp_lat = ATTEMPTS * (1 + INH + TO);
    cyc = 1;
    while (!ifc.tx_err && !ifc.tx_done && cyc < exp_lat + 100) begin cyc++; step(); end
    n_checks++;
    if (cyc >= exp_lat - 2 && cyc <= exp_lat + 2) n_pass++;
    else $display("FAIL timeout_latency: got %0d cycles, required %0d +/-2", cyc, exp_lat);
    check("timeout_err", {ifc.tx_done, ifc.tx_err, ifc.busy}, 3'b010);
    check("timeout_lines_released", {ps2_clk_w, ps2_dat_w}, 2'b11);
    step();
    check("timeout_pulse_width", ifc.tx_err, 0);
    $display("timeout: err after %0d cycles", cyc);
    dev_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
